// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the memory stage: request function/mask types,
// load/store unit FSM states and fault causes.
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    M_X   = 2'd0,
    M_XRD = 2'd1,
    M_XWR = 2'd2
  } mem_fcn_e;

  typedef enum logic [2:0] {
    MT_X  = 3'd0,
    MT_B  = 3'd1,
    MT_H  = 3'd2,
    MT_W  = 3'd3,
    MT_BU = 3'd4,
    MT_HU = 3'd5
  } mem_typ_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  typedef enum logic [1:0] {
    FAULT_NONE       = 2'd0,
    FAULT_MISALIGNED = 2'd1,
    FAULT_TIMEOUT    = 2'd2
  } fault_cause_e;

  // Halfwords need an even address and words a word-aligned one; bytes and
  // the untyped MT_X never fault.
  function automatic logic is_misaligned(input logic [2:0] typ, input logic [1:0] off);
    case (typ)
      MT_H, MT_HU: return off[0];
      MT_W:        return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering between right-aligned pipeline data and the 32-bit bus:
// byte enables, store replication and sign/zero-extending load extraction.
module lsu_lane_align
  import load_store_unit_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  typ,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext
);

  logic [31:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  // NOTE: every output gets a default before the case so no path through
  // this block can leave a signal unassigned and infer a latch.
  always_comb begin
    be        = 4'hF;
    wdata_rep = wdata;
    rdata_ext = shifted;
    case (typ)
      MT_B: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {{24{shifted[7]}}, shifted[7:0]};
      end
      MT_BU: begin
        be        = 4'b0001 << off;
        wdata_rep = {4{wdata[7:0]}};
        rdata_ext = {24'h0, shifted[7:0]};
      end
      MT_H: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {{16{shifted[15]}}, shifted[15:0]};
      end
      MT_HU: begin
        be        = 4'b0011 << off;
        wdata_rep = {2{wdata[15:0]}};
        rdata_ext = {16'h0, shifted[15:0]};
      end
      default: ;  // MT_W and MT_X move the whole word
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: turns pipeline data-memory requests into
// word-aligned valid/ready bus transactions and stalls the pipeline meanwhile.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_fcn,
  input  logic [2:0]        req_typ,
  input  logic [31:0]       req_wdata,
  output logic              res_valid,
  output logic [31:0]       res_data,
  output logic              cmiss_stall,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              bus_req_we,
  output logic [3:0]        bus_req_be,
  output logic [31:0]       bus_req_wdata,
  input  logic              bus_rsp_valid,
  input  logic [31:0]       bus_rsp_data,
  output logic              fault_valid,
  output logic [1:0]        fault_cause,
  output logic [ADDR_W-1:0] fault_addr
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  // Last WAIT cycle index before the timeout fires (counter starts at 0).
  localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_e        state;
  logic [ADDR_W-1:0] cap_addr;
  logic [2:0]        cap_typ;
  logic [CNT_W-1:0]  timer;

  logic        req_active;
  logic        req_misaligned;
  logic        req_start;
  logic [1:0]  lane_off;
  logic [2:0]  lane_typ;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

  assign req_active     = req_valid && (req_fcn == M_XRD || req_fcn == M_XWR);
  assign req_misaligned = is_misaligned(req_typ, req_addr[1:0]);
  assign req_start      = (state == LSU_IDLE) && req_active && !req_misaligned;

  // The freeze must rise in the request cycle itself, so it is decoded
  // combinationally; reset forces it low along with every other output.
  assign cmiss_stall = rst_n && (req_start || state == LSU_REQ || state == LSU_WAIT);

  // One aligner serves both directions: live request fields while IDLE
  // (store lanes, byte enables), captured fields afterwards (load extract).
  assign lane_off = (state == LSU_IDLE) ? req_addr[1:0] : cap_addr[1:0];
  assign lane_typ = (state == LSU_IDLE) ? req_typ : cap_typ;

  lsu_lane_align u_lane_align (
    .off       (lane_off),
    .typ       (lane_typ),
    .wdata     (req_wdata),
    .rdata     (bus_rsp_data),
    .be        (lane_be),
    .wdata_rep (lane_wdata),
    .rdata_ext (lane_rdata)
  );

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LSU_IDLE;
      cap_addr      <= '0;
      cap_typ       <= '0;
      timer         <= '0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      bus_req_valid <= 1'b0;
      bus_req_addr  <= '0;
      bus_req_we    <= 1'b0;
      bus_req_be    <= '0;
      bus_req_wdata <= '0;
      fault_valid   <= 1'b0;
      fault_cause   <= FAULT_NONE;
      fault_addr    <= '0;
    end else begin
      // Result and fault are single-cycle pulses.
      res_valid   <= 1'b0;
      res_data    <= '0;
      fault_valid <= 1'b0;
      fault_cause <= FAULT_NONE;

      case (state)
        LSU_IDLE: begin
          if (req_valid) begin
            if (!req_active) begin
              res_valid <= 1'b1;
            end else if (req_misaligned) begin
              res_valid   <= 1'b1;
              fault_valid <= 1'b1;
              fault_cause <= FAULT_MISALIGNED;
              fault_addr  <= req_addr;
            end else begin
              cap_addr      <= req_addr;
              cap_typ       <= req_typ;
              timer         <= '0;
              bus_req_valid <= 1'b1;
              bus_req_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
              bus_req_we    <= (req_fcn == M_XWR);
              bus_req_be    <= lane_be;
              bus_req_wdata <= lane_wdata;
              state         <= LSU_REQ;
            end
          end
        end

        LSU_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            if (bus_req_we) begin
              res_valid <= 1'b1;
              state     <= LSU_DONE;
            end else begin
              state <= LSU_WAIT;
            end
          end
        end

        LSU_WAIT: begin
          // A response in the expiry cycle still wins over the timeout.
          if (bus_rsp_valid) begin
            res_valid <= 1'b1;
            res_data  <= lane_rdata;
            timer     <= '0;
            state     <= LSU_DONE;
          end else if (timer == TIMER_LAST) begin
            res_valid   <= 1'b1;
            fault_valid <= 1'b1;
            fault_cause <= FAULT_TIMEOUT;
            fault_addr  <= cap_addr;
            timer       <= '0;
            state       <= LSU_DONE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        // The stalled instruction is still presented here; it is never
        // recaptured because the pipeline advances at the end of DONE.
        LSU_DONE: state <= LSU_IDLE;

        default: state <= LSU_IDLE;
      endcase
    end
  end

endmodule
